pwm_capture: RTL
================

# pwm_capture

Pulse-width demodulator: the receive-side counterpart of the LED PWM generator. Samples an external PWM waveform on `sysclk`, measures high time and period between consecutive rising edges, and reports the recovered duty value (brightness code) with a one-cycle valid strobe. Sits between an input pin (or a loop-back of the generator output) and the SPI register file, so the host can read back the brightness actually being driven.

## Interface
- `WIDTH`, 8: brightness code width; nominal PWM period is 2^WIDTH `sysclk` cycles.
- `TIMEOUT`, 2*2^WIDTH: cycles without a rising edge before the input is declared static.

- `sysclk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_enb`  in  1  capture enable; low forces IDLE.
- `i_pwm`  in  1  PWM input, asynchronous to `sysclk`.
- `o_duty`  out  WIDTH  last accepted duty value (high-time cycles per period).
- `o_valid`  out  1  one-cycle strobe: `o_duty` updated this cycle.
- `o_period_err`  out  1  one-cycle strobe: measured period ≠ 2^WIDTH, sample rejected.
- `o_static`  out  1  level: input has had no rising edge for `TIMEOUT` cycles.
- `o_period`  out  WIDTH+2  last measured rise-to-rise period (debug readback).

## Operation
- Input path: 2-flop synchronizer → `s_pwm`; `s_prev` = `s_pwm` delayed 1 cycle; `rise` = `s_pwm & ~s_prev` (combinational). Synchronizer and `s_prev` run regardless of `i_enb`; reset to 0.
- Counters: `per_cnt` (WIDTH+2 bits, saturates at `TIMEOUT`), `hi_cnt` (WIDTH+1 bits, saturates at 2^WIDTH).
  - Cycle with `rise`: `per_cnt` ← 1, `hi_cnt` ← 1.
  - Other cycles: `per_cnt` ← `per_cnt`+1; `hi_cnt` ← `hi_cnt` + `s_pwm`.
  - At a `rise`, pre-update values are exactly period and high time of the preceding cycle window.
- States:
  - IDLE: `i_enb`=0. Counters cleared, strobes 0, `o_static`=0, `o_duty`/`o_period` hold. `i_enb`=1 → HUNT.
  - HUNT: wait for first `rise` (nothing reported) → MEASURE. `per_cnt` reaching `TIMEOUT` → STATIC.
  - MEASURE: on `rise`: `o_period` ← `per_cnt`; if `per_cnt` = 2^WIDTH and `hi_cnt` < 2^WIDTH: `o_duty` ← `hi_cnt[WIDTH-1:0]`, `o_valid`=1; else `o_period_err`=1, `o_duty` unchanged. Stay MEASURE. `per_cnt` reaching `TIMEOUT` → STATIC.
  - STATIC: on entry `o_static`=1, one `o_valid` strobe with `o_duty` = 0 if `s_pwm`=0, all-ones if `s_pwm`=1. `rise` → MEASURE (`o_static`←0; that first rise reports nothing).
- `i_enb` falling in any state → IDLE next cycle; a `rise` in that same cycle is ignored.
- `o_valid` and `o_period_err` never both high.

## Timing
- Reset values: `o_duty`=0, `o_valid`=0, `o_period_err`=0, `o_static`=0, `o_period`=0, state IDLE, counters 0.
- Latency: `i_pwm` first sampled high at edge t → `s_pwm`=1 after edge t+1 → strobes registered at edge t+2 (high for cycle after t+2).
- Strobes are exactly 1 cycle wide; `o_duty`/`o_period` change only with a strobe (or reset).
- Static detection: `o_static` rises `TIMEOUT`+1 cycles after the last `rise` (or after entering HUNT).
- Reset mid-period: all state and outputs return to reset values immediately; after release, capture restarts in IDLE/HUNT.

## Test plan
- Generator loop-back, WIDTH=8, duty 100, period 256 → after first rise, every 256 cycles `o_valid`=1 with `o_duty`=100, `o_period`=256, no `o_period_err`.
- Duty 1 and duty 255 → `o_duty`=1 and 255 respectively, period 256, no errors.
- Period 250, duty 80 → `o_period_err` pulse each period, `o_period`=250, `o_duty` keeps prior value, `o_valid` never asserts.
- `i_pwm` held low 600 cycles after valid captures → `o_static`=1 at 513 cycles after last rise, one `o_valid` with `o_duty`=0; resume PWM duty 40 → `o_static` clears on first rise, next rise reports 40.
- `i_enb` dropped mid-period then raised, and `i_rst_n` pulsed mid-period → no strobe while disabled; first post-enable rise silent, second reports correct duty; reset clears `o_duty` to 0.

Source files
------------

// File: rtl/pwm_capture.sv
// Pulse-width demodulator. It measures the high time and the rise-to-rise period of a sampled PWM input
// and reports the recovered duty code, flags periods of the wrong length and flags an input that has stopped toggling.
module pwm_capture #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 2 * (2 ** WIDTH)
) (
   input  logic               sysclk,
   input  logic               i_rst_n,
   input  logic               i_enb,
   input  logic               i_pwm,
   output logic [WIDTH-1:0]   o_duty,
   output logic               o_valid,
   output logic               o_period_err,
   output logic               o_static,
   output logic [WIDTH+1:0]   o_period
);

   typedef enum logic [1:0] {
      IDLE,
      HUNT,
      MEASURE,
      STATIC
   } state_t;

   localparam logic [WIDTH+1:0] PER_NOM = {2'b01, {WIDTH{1'b0}}};
   localparam logic [WIDTH+1:0] PER_MAX = (WIDTH+2)'(TIMEOUT);
   localparam logic [WIDTH+1:0] PER_ONE = {{(WIDTH+1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   HI_MAX  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0]   HI_ONE  = {{WIDTH{1'b0}}, 1'b1};

   state_t             r_state;
   logic               r_sync1;
   logic               r_spwm;
   logic               r_sprev;
   logic [WIDTH+1:0]   r_per_cnt;
   logic [WIDTH:0]     r_hi_cnt;
   logic [WIDTH-1:0]   r_duty;
   logic [WIDTH+1:0]   r_period;
   logic               r_valid;
   logic               r_period_err;
   logic               r_static;

   logic               w_rise;
   logic [WIDTH+1:0]   w_per_inc;
   logic [WIDTH:0]     w_hi_inc;
   logic               w_timeout;
   logic               w_good;

   // The synchronizer stays active while capture is disabled, so enabling never produces a stale edge.
   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_spwm  <= 1'b0;
         r_sprev <= 1'b0;
      end else begin
         r_sync1 <= i_pwm;
         r_spwm  <= r_sync1;
         r_sprev <= r_spwm;
      end
   end

   assign w_rise = r_spwm & ~r_sprev;

   always_comb begin
      w_per_inc = (r_per_cnt >= PER_MAX) ? PER_MAX : r_per_cnt + PER_ONE;
      w_hi_inc  = (r_hi_cnt >= HI_MAX) ? HI_MAX
                                       : r_hi_cnt + {{WIDTH{1'b0}}, r_spwm};
      w_timeout = (r_per_cnt == PER_MAX);
      w_good    = (r_per_cnt == PER_NOM) && (r_hi_cnt < HI_MAX);
   end

   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_per_cnt    <= '0;
         r_hi_cnt     <= '0;
         r_duty       <= '0;
         r_period     <= '0;
         r_valid      <= 1'b0;
         r_period_err <= 1'b0;
         r_static     <= 1'b0;
      end else begin
         // NOTE: the strobes default low on every edge, which guarantees a one-cycle pulse from any branch that sets them.
         r_valid      <= 1'b0;
         r_period_err <= 1'b0;

         if (!i_enb) begin
            r_state   <= IDLE;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_static  <= 1'b0;
         end else if (r_state == IDLE) begin
            r_state   <= HUNT;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_static  <= 1'b0;
         end else begin
            // At a rise, the counter values before this update describe the window that just ended.
            r_per_cnt <= w_rise ? PER_ONE : w_per_inc;
            r_hi_cnt  <= w_rise ? HI_ONE  : w_hi_inc;

            case (r_state)
               HUNT: begin
                  if (w_rise) begin
                     r_state <= MEASURE;
                  end else if (w_timeout) begin
                     r_state  <= STATIC;
                     r_static <= 1'b1;
                     r_valid  <= 1'b1;
                     r_duty   <= {WIDTH{r_spwm}};
                  end
               end

               MEASURE: begin
                  if (w_rise) begin
                     r_period <= r_per_cnt;
                     if (w_good) begin
                        r_duty  <= r_hi_cnt[WIDTH-1:0];
                        r_valid <= 1'b1;
                     end else begin
                        r_period_err <= 1'b1;
                     end
                  end else if (w_timeout) begin
                     r_state  <= STATIC;
                     r_static <= 1'b1;
                     r_valid  <= 1'b1;
                     r_duty   <= {WIDTH{r_spwm}};
                  end
               end

               STATIC: begin
                  if (w_rise) begin
                     r_state  <= MEASURE;
                     r_static <= 1'b0;
                  end
               end

               IDLE: begin
                  r_state <= HUNT;
               end
            endcase
         end
      end
   end

   assign o_duty       = r_duty;
   assign o_valid      = r_valid;
   assign o_period_err = r_period_err;
   assign o_static     = r_static;
   assign o_period     = r_period;

   a_strobe_excl: assert property (@(posedge sysclk) disable iff (!i_rst_n)
                                   !(o_valid && o_period_err));
   a_valid_pulse: assert property (@(posedge sysclk) disable iff (!i_rst_n)
                                   o_valid |=> !o_valid);

endmodule
